// File: rtl/step_seq_pkg.sv
// Shared constants and types for the step sequence counter.
// This package is imported by the next-value sub-module and by the top.
package step_seq_pkg;

  localparam logic DIR_UP    = 1'b1;
  localparam logic DIR_DOWN  = 1'b0;
  localparam logic MODE_WRAP = 1'b1;
  localparam logic MODE_SAT  = 1'b0;

  // Which source wins the count register on a given edge.
  typedef enum logic [1:0] {
    ACT_HOLD   = 2'd0,
    ACT_LOAD   = 2'd1,
    ACT_REJECT = 2'd2,
    ACT_COUNT  = 2'd3
  } action_e;

endpackage : step_seq_pkg

// File: rtl/step_seq_next.sv
// Combinational legality check and next-count computation for step_seq_counter.
// All arithmetic is carried one bit wider than the count so that count+STEP never aliases.
module step_seq_next
  import step_seq_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int STEP    = 2,
  parameter int MIN_VAL = 0,
  parameter int MAX_VAL = 8
) (
  input  logic [WIDTH-1:0] count,
  input  logic             up_dn,
  input  logic             wrap_mode,
  input  logic [WIDTH-1:0] load_val,
  output logic             count_legal,
  output logic             load_legal,
  output logic             at_max,
  output logic             at_min,
  output logic [WIDTH-1:0] next_val
);

  localparam int             EW     = WIDTH + 1;
  localparam logic [WIDTH:0] MIN_E  = EW'(MIN_VAL);
  localparam logic [WIDTH:0] MAX_E  = EW'(MAX_VAL);
  localparam logic [WIDTH:0] STEP_E = EW'(STEP);

  function automatic logic is_legal(input logic [WIDTH:0] v);
    logic [WIDTH:0] off;
    off = v - MIN_E;
    return (v >= MIN_E) && (v <= MAX_E) && ((off % STEP_E) == '0);
  endfunction

  logic [WIDTH:0] count_e;
  logic [WIDTH:0] sum_e;
  logic [WIDTH:0] diff_e;
  logic [WIDTH:0] next_e;

  // NOTE: always_comb assigns every output a default first so no latch is inferred.
  always_comb begin
    count_e     = {1'b0, count};
    sum_e       = count_e + STEP_E;
    diff_e      = count_e - STEP_E;
    count_legal = is_legal(count_e);
    load_legal  = is_legal({1'b0, load_val});
    at_max      = (count_e == MAX_E);
    at_min      = (count_e == MIN_E);
    next_e      = MIN_E;

    // An illegal count falls through to MIN_VAL regardless of direction or mode.
    if (count_legal) begin
      if (up_dn == DIR_UP) begin
        if (at_max) next_e = (wrap_mode == MODE_WRAP) ? MIN_E : MAX_E;
        else        next_e = sum_e;
      end else begin
        if (at_min) next_e = (wrap_mode == MODE_WRAP) ? MAX_E : MIN_E;
        else        next_e = diff_e;
      end
    end

    next_val = WIDTH'(next_e);
  end

endmodule : step_seq_next

// File: rtl/step_seq_counter.sv
// Up/down counter that moves in STEP increments between MIN_VAL and MAX_VAL,
// with wrap or saturate at the bounds, validated synchronous load and terminal count.
module step_seq_counter
  import step_seq_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int STEP        = 2,
  parameter int MIN_VAL     = 0,
  parameter int MAX_VAL     = 8,
  parameter int RESET_VALUE = 0
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             cnt_en,
  input  logic             up_dn,
  input  logic             wrap_mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             load_err
);

  // Illegal parameter sets stop elaboration.
  if (STEP < 1) begin : g_bad_step
    $error("step_seq_counter: STEP must be >= 1");
  end
  if ((MAX_VAL >= (1 << WIDTH)) || (MAX_VAL <= MIN_VAL) || (MIN_VAL < 0)) begin : g_bad_range
    $error("step_seq_counter: require 0 <= MIN_VAL < MAX_VAL < 2**WIDTH");
  end
  if ((STEP >= 1) && (((MAX_VAL - MIN_VAL) % STEP) != 0)) begin : g_bad_span
    $error("step_seq_counter: MAX_VAL-MIN_VAL must be divisible by STEP");
  end
  if ((STEP >= 1) && ((RESET_VALUE < MIN_VAL) || (RESET_VALUE > MAX_VAL) ||
                      (((RESET_VALUE - MIN_VAL) % STEP) != 0))) begin : g_bad_reset
    $error("step_seq_counter: RESET_VALUE must be a legal count value");
  end

  localparam logic [WIDTH-1:0] MIN_W   = WIDTH'(MIN_VAL);
  localparam logic [WIDTH-1:0] RESET_W = WIDTH'(RESET_VALUE);

  logic [WIDTH-1:0] count_q, count_d;
  logic             load_err_q, load_err_d;
  logic             count_legal;
  logic             load_legal;
  logic             at_max;
  logic             at_min;
  logic [WIDTH-1:0] next_val;
  action_e          action;

  step_seq_next #(
    .WIDTH  (WIDTH),
    .STEP   (STEP),
    .MIN_VAL(MIN_VAL),
    .MAX_VAL(MAX_VAL)
  ) u_next (
    .count      (count_q),
    .up_dn      (up_dn),
    .wrap_mode  (wrap_mode),
    .load_val   (load_val),
    .count_legal(count_legal),
    .load_legal (load_legal),
    .at_max     (at_max),
    .at_min     (at_min),
    .next_val   (next_val)
  );

  always_comb begin
    action     = ACT_HOLD;
    count_d    = count_q;
    load_err_d = 1'b0;

    if (load)        action = load_legal ? ACT_LOAD : ACT_REJECT;
    else if (cnt_en) action = ACT_COUNT;

    unique case (action)
      ACT_LOAD:   count_d = load_val;
      ACT_REJECT: begin
        count_d    = MIN_W;
        load_err_d = 1'b1;
      end
      ACT_COUNT:  count_d = next_val;
      default:    count_d = count_q;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rstb) begin
      count_q    <= RESET_W;
      load_err_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      load_err_q <= load_err_d;
    end
  end

  // Terminal count flags an attempted step past a bound, in either mode.
  assign tc       = rstb && cnt_en && !load &&
                    (((up_dn == DIR_UP) && at_max) || ((up_dn == DIR_DOWN) && at_min));
  assign count    = count_q;
  assign load_err = load_err_q;

endmodule : step_seq_counter

// File: tb/tb_step_seq_counter.sv
// Directed self-checking bench: a default-parameter instance and a
// WIDTH=8/STEP=3/MIN=10/MAX=40 instance, each with its own inputs.
module tb_step_seq_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Default instance
  logic       rstb, cnt_en, up_dn, wrap_mode, load;
  logic [3:0] load_val, count;
  logic       tc, load_err;

  // Wide instance
  logic       rstb_b, cnt_en_b, up_dn_b, wrap_mode_b, load_b;
  logic [7:0] load_val_b, count_b;
  logic       tc_b, load_err_b;

  int pass_cnt  = 0;
  int total_cnt = 0;

  step_seq_counter dut (
    .clk      (clk),
    .rstb     (rstb),
    .cnt_en   (cnt_en),
    .up_dn    (up_dn),
    .wrap_mode(wrap_mode),
    .load     (load),
    .load_val (load_val),
    .count    (count),
    .tc       (tc),
    .load_err (load_err)
  );

  step_seq_counter #(
    .WIDTH      (8),
    .STEP       (3),
    .MIN_VAL    (10),
    .MAX_VAL    (40),
    .RESET_VALUE(10)
  ) dut_b (
    .clk      (clk),
    .rstb     (rstb_b),
    .cnt_en   (cnt_en_b),
    .up_dn    (up_dn_b),
    .wrap_mode(wrap_mode_b),
    .load     (load_b),
    .load_val (load_val_b),
    .count    (count_b),
    .tc       (tc_b),
    .load_err (load_err_b)
  );

  // Advance one rising edge, then settle before sampling or driving.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstb = 1'b0; load = 1'b1; load_val = 4'd6; cnt_en = 1'b1; up_dn = 1'b0; wrap_mode = 1'b1;
    tick();
    tick();
    total_cnt++;
    if (count !== 4'd0) $display("FAIL reset_count: got %0d want 0", count);
    else pass_cnt++;
    total_cnt++;
    if (load_err !== 1'b0) $display("FAIL reset_load_err: got %b want 0", load_err);
    else pass_cnt++;
    // count==MIN with down and cnt_en would raise tc if not in reset
    total_cnt++;
    if (tc !== 1'b0) $display("FAIL reset_tc: got %b want 0", tc);
    else pass_cnt++;
    rstb = 1'b1; load = 1'b0; cnt_en = 1'b0;
    #1;
  endtask

  task automatic test_up_wrap();
    logic [3:0] exp_cnt [6] = '{4'd2, 4'd4, 4'd6, 4'd8, 4'd0, 4'd2};
    up_dn = 1'b1; wrap_mode = 1'b1; cnt_en = 1'b1;
    #1;
    total_cnt++;
    if (tc !== 1'b0) $display("FAIL up_wrap_tc_start: got %b want 0", tc);
    else pass_cnt++;
    for (int i = 0; i < 6; i++) begin
      tick();
      total_cnt++;
      if (count !== exp_cnt[i]) $display("FAIL up_wrap_count[%0d]: got %0d want %0d", i, count, exp_cnt[i]);
      else pass_cnt++;
      total_cnt++;
      if (tc !== (exp_cnt[i] == 4'd8)) $display("FAIL up_wrap_tc[%0d]: got %b want %b", i, tc, exp_cnt[i] == 4'd8);
      else pass_cnt++;
    end
    cnt_en = 1'b0;
    tick();
    total_cnt++;
    if (count !== 4'd2 || tc !== 1'b0) $display("FAIL hold: got count=%0d tc=%b want 2/0", count, tc);
    else pass_cnt++;
  endtask

  task automatic test_down_and_saturate();
    load = 1'b1; load_val = 4'd0;
    tick();
    load = 1'b0; up_dn = 1'b0; wrap_mode = 1'b1; cnt_en = 1'b1;
    #1;
    total_cnt++;
    if (tc !== 1'b1) $display("FAIL down_wrap_tc: got %b want 1", tc);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (count !== 4'd8) $display("FAIL down_wrap_first: got %0d want 8", count);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (count !== 4'd6) $display("FAIL down_step: got %0d want 6", count);
    else pass_cnt++;
    // Saturate low
    cnt_en = 1'b0; load = 1'b1; load_val = 4'd0;
    tick();
    load = 1'b0; cnt_en = 1'b1; wrap_mode = 1'b0;
    tick();
    total_cnt++;
    if (count !== 4'd0 || tc !== 1'b1) $display("FAIL sat_low: got count=%0d tc=%b want 0/1", count, tc);
    else pass_cnt++;
    // Saturate high
    cnt_en = 1'b0; load = 1'b1; load_val = 4'd8;
    tick();
    load = 1'b0; cnt_en = 1'b1; up_dn = 1'b1;
    tick();
    total_cnt++;
    if (count !== 4'd8 || tc !== 1'b1) $display("FAIL sat_high: got count=%0d tc=%b want 8/1", count, tc);
    else pass_cnt++;
    cnt_en = 1'b0;
    #1;
  endtask

  task automatic test_load();
    load = 1'b1; load_val = 4'd5; cnt_en = 1'b0;
    tick();
    total_cnt++;
    if (count !== 4'd0 || load_err !== 1'b1) $display("FAIL load_odd: got count=%0d err=%b want 0/1", count, load_err);
    else pass_cnt++;
    load_val = 4'd6; cnt_en = 1'b1; up_dn = 1'b1;
    #1;
    total_cnt++;
    if (tc !== 1'b0) $display("FAIL load_masks_tc: got %b want 0", tc);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (count !== 4'd6 || load_err !== 1'b0) $display("FAIL load_legal: got count=%0d err=%b want 6/0", count, load_err);
    else pass_cnt++;
    load_val = 4'd10; cnt_en = 1'b0;
    tick();
    total_cnt++;
    if (count !== 4'd0 || load_err !== 1'b1) $display("FAIL load_range: got count=%0d err=%b want 0/1", count, load_err);
    else pass_cnt++;
    load = 1'b0;
    tick();
    total_cnt++;
    if (count !== 4'd0 || load_err !== 1'b0) $display("FAIL load_err_clear: got count=%0d err=%b want 0/0", count, load_err);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    load = 1'b1; load_val = 4'd4;
    tick();
    load = 1'b0; cnt_en = 1'b1; up_dn = 1'b1; wrap_mode = 1'b1;
    tick();
    total_cnt++;
    if (count !== 4'd6) $display("FAIL mid_pre: got %0d want 6", count);
    else pass_cnt++;
    rstb = 1'b0; load = 1'b1; load_val = 4'd5;
    tick();
    total_cnt++;
    if (count !== 4'd0 || load_err !== 1'b0) $display("FAIL mid_reset: got count=%0d err=%b want 0/0", count, load_err);
    else pass_cnt++;
    rstb = 1'b1; load = 1'b0;
    tick();
    total_cnt++;
    if (count !== 4'd2) $display("FAIL mid_resume: got %0d want 2", count);
    else pass_cnt++;
    cnt_en = 1'b0;
  endtask

  task automatic test_params();
    logic [7:0] exp_v;
    rstb_b = 1'b0; cnt_en_b = 1'b1; up_dn_b = 1'b1; wrap_mode_b = 1'b0; load_b = 1'b1; load_val_b = 8'd25;
    tick();
    rstb_b = 1'b1; load_b = 1'b0;
    total_cnt++;
    if (count_b !== 8'd10) $display("FAIL p_reset: got %0d want 10", count_b);
    else pass_cnt++;
    exp_v = 8'd10;
    for (int i = 0; i < 11; i++) begin
      tick();
      if (exp_v != 8'd40) exp_v = exp_v + 8'd3;
      total_cnt++;
      if (count_b !== exp_v) $display("FAIL p_up[%0d]: got %0d want %0d", i, count_b, exp_v);
      else pass_cnt++;
    end
    total_cnt++;
    if (tc_b !== 1'b1) $display("FAIL p_tc_max: got %b want 1", tc_b);
    else pass_cnt++;
    load_b = 1'b1; load_val_b = 8'd11;
    tick();
    total_cnt++;
    if (count_b !== 8'd10 || load_err_b !== 1'b1) $display("FAIL p_load_bad: got count=%0d err=%b want 10/1", count_b, load_err_b);
    else pass_cnt++;
    load_b = 1'b0; up_dn_b = 1'b0; wrap_mode_b = 1'b1;
    #1;
    total_cnt++;
    if (tc_b !== 1'b1) $display("FAIL p_tc_min: got %b want 1", tc_b);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (count_b !== 8'd40) $display("FAIL p_down_wrap: got %0d want 40", count_b);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (count_b !== 8'd37) $display("FAIL p_down_step: got %0d want 37", count_b);
    else pass_cnt++;
    cnt_en_b = 1'b0;
  endtask

  initial begin
    rstb = 1'b0; cnt_en = 1'b0; up_dn = 1'b1; wrap_mode = 1'b1; load = 1'b0; load_val = '0;
    rstb_b = 1'b0; cnt_en_b = 1'b0; up_dn_b = 1'b1; wrap_mode_b = 1'b0; load_b = 1'b0; load_val_b = '0;
    @(negedge clk);
    test_reset();
    test_up_wrap();
    test_down_and_saturate();
    test_load();
    test_reset_mid();
    test_params();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule : tb_step_seq_counter
